fb_line_loader: RTL and testbench

- Sequences writes into the framebuffer line BRAM from the UART byte stream, on the 27 MHz domain.
- Parses the text protocol: '#' = frame start, '+' = commit line, hex digits = 4 pixels each.
- Packs the hex digits into a PIXELS-wide line word and issues one BRAM write per committed line.
- Sits between uart_rx (o_READY/o_DATA) and the BRAM write port; the PAL generator reads the other port.

---
 rtl/fb_line_loader.sv | 155 +++++++++++++++
 tb/tb_fb_line_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_line_loader.sv
`default_nettype none
// ============================================================================
// Module      : fb_line_loader
// Description : Turns the UART text stream into framebuffer line writes.
//               '#' restarts the frame, hex digits fill a PIXELS-wide line
//               word four pixels at a time, and '+' commits the word to the
//               line BRAM and advances the line counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_line_loader #(
    parameter int PIXELS = 300,
    parameter int LINES  = 608,
    parameter int ADDR_W = 10
) (
    input  logic              i_CLK,
    input  logic              i_RST_N,
    input  logic              i_READY,
    input  logic [7:0]        i_DATA,
    output logic              o_WR_EN,
    output logic [ADDR_W-1:0] o_WR_ADDR,
    output logic [PIXELS-1:0] o_WR_DATA,
    output logic [ADDR_W-1:0] o_LINE,
    output logic              o_FRAME_DONE,
    output logic [7:0]        o_ERR_CNT
);

    localparam int NIBBLES = PIXELS / 4;
    localparam int IDX_W   = $clog2(NIBBLES + 1);

    localparam logic [7:0]        C_HASH     = 8'h23;
    localparam logic [7:0]        C_PLUS     = 8'h2B;
    localparam logic [7:0]        C_CR       = 8'h0D;
    localparam logic [7:0]        C_LF       = 8'h0A;
    localparam logic [ADDR_W-1:0] C_LAST     = ADDR_W'(LINES - 1);
    localparam logic [IDX_W-1:0]  C_LAST_NIB = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_ready_prev;
    logic [PIXELS-1:0]   r_acc;
    logic [IDX_W-1:0]    r_idx;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [PIXELS-1:0]   r_wr_data;
    logic [ADDR_W-1:0]   r_line;
    logic                r_frame_done;
    logic [7:0]          r_err_cnt;

    logic                w_strobe;
    logic                w_is_hex;
    logic [3:0]          w_nib;
    logic [IDX_W+1:0]    w_base;
    logic [7:0]          w_err_inc;

    // uart_rx holds READY as a level; only its rising edge marks a new byte
    assign w_strobe  = i_READY & ~r_ready_prev;
    // Bit offset of the next nibble slot inside the line word
    assign w_base    = {r_idx, 2'b00};
    // Saturating increment for the rejected-byte counter
    assign w_err_inc = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;

    // Decode an ASCII hex digit into its 4-bit value
    always_comb begin
        w_is_hex = 1'b1;
        w_nib    = 4'h0;
        if (i_DATA >= 8'h30 && i_DATA <= 8'h39) begin
            w_nib = i_DATA[3:0];
        end else if ((i_DATA >= 8'h41 && i_DATA <= 8'h46) ||
                     (i_DATA >= 8'h61 && i_DATA <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so +9 maps them onto 10..15
            w_nib = i_DATA[3:0] + 4'd9;
        end else begin
            w_is_hex = 1'b0;
        end
    end

    // Register the READY level for edge detection
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_ready_prev <= 1'b0;
        end else begin
            r_ready_prev <= i_READY;
        end
    end

    // Protocol FSM: accumulate nibbles, commit lines, count rejected bytes
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_state      <= S_IDLE;
            r_acc        <= '0;
            r_idx        <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_line       <= '0;
            r_frame_done <= 1'b0;
            r_err_cnt    <= 8'd0;
        end else begin
            // Write enable and frame-done are single-cycle pulses
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_strobe) begin
                if (i_DATA == C_HASH) begin
                    // Frame restart drops any pending pixels without writing
                    r_acc   <= '0;
                    r_idx   <= '0;
                    r_line  <= '0;
                    r_state <= S_IDLE;
                end else if (i_DATA == C_PLUS) begin
                    // Unfilled nibbles are still zero, so short lines pad black
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_line;
                    r_wr_data <= r_acc;
                    r_acc     <= '0;
                    r_idx     <= '0;
                    r_state   <= S_IDLE;
                    if (r_line == C_LAST) begin
                        r_line       <= '0;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_line <= r_line + 1'b1;
                    end
                end else if (w_is_hex) begin
                    if (r_state == S_FULL) begin
                        // Line word already full: the extra digit is rejected
                        r_err_cnt <= w_err_inc;
                    end else begin
                        r_acc[w_base +: 4] <= w_nib;
                        r_idx              <= r_idx + 1'b1;
                        r_state            <= (r_idx == C_LAST_NIB) ? S_FULL : S_LOAD;
                    end
                end else if (i_DATA == C_CR || i_DATA == C_LF) begin
                    // Line endings are formatting only
                    r_state <= r_state;
                end else begin
                    r_err_cnt <= w_err_inc;
                end
            end
        end
    end

    assign o_WR_EN      = r_wr_en;
    assign o_WR_ADDR    = r_wr_addr;
    assign o_WR_DATA    = r_wr_data;
    assign o_LINE       = r_line;
    assign o_FRAME_DONE = r_frame_done;
    assign o_ERR_CNT    = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fb_line_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_line_loader
// Description : Self-checking bench for fb_line_loader. A table of bytes with
//               hand-derived expected o_LINE / o_ERR_CNT / writes drives the
//               first part; hand-written sequences cover full lines, frame
//               wrap, pulse timing, counter saturation and async reset.
//               Expected writes go into a queue and are popped by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_line_loader;

    localparam int PIXELS = 300;
    localparam int LINES  = 608;
    localparam int ADDR_W = 10;

    logic              clk;
    logic              rst_n;
    logic              i_ready;
    logic [7:0]        i_data;
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [PIXELS-1:0] o_wr_data;
    logic [ADDR_W-1:0] o_line;
    logic              o_frame_done;
    logic [7:0]        o_err_cnt;

    fb_line_loader #(
        .PIXELS (PIXELS),
        .LINES  (LINES),
        .ADDR_W (ADDR_W)
    ) dut (
        .i_CLK        (clk),
        .i_RST_N      (rst_n),
        .i_READY      (i_ready),
        .i_DATA       (i_data),
        .o_WR_EN      (o_wr_en),
        .o_WR_ADDR    (o_wr_addr),
        .o_WR_DATA    (o_wr_data),
        .o_LINE       (o_line),
        .o_FRAME_DONE (o_frame_done),
        .o_ERR_CNT    (o_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [PIXELS-1:0] data;
        bit                fd;
    } wr_t;

    typedef struct {
        logic [7:0]        b;
        int                hold;
        bit                wr;
        logic [ADDR_W-1:0] addr;
        logic [PIXELS-1:0] data;
        logic [ADDR_W-1:0] line;
        logic [7:0]        err;
    } vec_t;

    wr_t q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  fd_cnt   = 0;

    task automatic chk(input string name, input logic [PIXELS-1:0] act,
                       input logic [PIXELS-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [ADDR_W-1:0] a,
                           input logic [PIXELS-1:0] d, input bit fd);
        wr_t w;
        w.addr = a;
        w.data = d;
        w.fd   = fd;
        q.push_back(w);
    endtask

    // Present one byte, keep READY high for 'hold' cycles, then drop it
    task automatic send(input logic [7:0] b, input int hold);
        @(negedge clk);
        i_ready = 1'b1;
        i_data  = b;
        repeat (hold) @(negedge clk);
        i_ready = 1'b0;
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic [7:0] b, input int hold, input bit wr,
                                input logic [ADDR_W-1:0] addr,
                                input logic [PIXELS-1:0] data,
                                input logic [ADDR_W-1:0] line,
                                input logic [7:0] err);
        vec_t v;
        v.b = b; v.hold = hold; v.wr = wr; v.addr = addr;
        v.data = data; v.line = line; v.err = err;
        return v;
    endfunction

    // Scoreboard: every write pulse must match the oldest expected write
    always @(negedge clk) begin
        if (rst_n && o_frame_done) fd_cnt++;
        if (rst_n && o_frame_done && !o_wr_en) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_done_without_write: got 1 expected 0");
        end
        if (rst_n && o_wr_en) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data %0h", o_wr_addr, o_wr_data);
            end else begin
                wr_t e;
                e = q.pop_front();
                chk("wr_addr", PIXELS'(o_wr_addr), PIXELS'(e.addr));
                chk("wr_data", o_wr_data, e.data);
                chk("wr_frame_done", PIXELS'(o_frame_done), PIXELS'(e.fd));
            end
        end
    end

    vec_t vecs[$];
    logic [PIXELS-1:0] all_ones;

    initial begin
        rst_n   = 1'b0;
        i_ready = 1'b0;
        i_data  = 8'h00;
        all_ones = '1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_wr_en", PIXELS'(o_wr_en), '0);
        chk("rst_wr_addr", PIXELS'(o_wr_addr), '0);
        chk("rst_wr_data", o_wr_data, '0);
        chk("rst_line", PIXELS'(o_line), '0);
        chk("rst_frame_done", PIXELS'(o_frame_done), '0);
        chk("rst_err_cnt", PIXELS'(o_err_cnt), '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Byte table: expected o_LINE and o_ERR_CNT after each byte
        vecs.push_back(mk(8'h33, 1,  0, 0, 0,       0, 0)); // '3'
        vecs.push_back(mk(8'h41, 1,  0, 0, 0,       0, 0)); // 'A'
        vecs.push_back(mk(8'h2B, 1,  1, 0, 'hA3,    1, 0)); // '+'
        vecs.push_back(mk(8'h31, 1,  0, 0, 0,       1, 0)); // '1'
        vecs.push_back(mk(8'h32, 1,  0, 0, 0,       1, 0)); // '2'
        vecs.push_back(mk(8'h23, 1,  0, 0, 0,       0, 0)); // '#'
        vecs.push_back(mk(8'h2B, 1,  1, 0, 0,       1, 0)); // '+'
        vecs.push_back(mk(8'h67, 50, 0, 0, 0,       1, 1)); // 'g'
        vecs.push_back(mk(8'h0D, 50, 0, 0, 0,       1, 1)); // CR
        vecs.push_back(mk(8'h0A, 50, 0, 0, 0,       1, 1)); // LF
        vecs.push_back(mk(8'h7A, 50, 0, 0, 0,       1, 2)); // 'z'
        vecs.push_back(mk(8'h61, 50, 0, 0, 0,       1, 2)); // 'a'
        vecs.push_back(mk(8'h2B, 50, 1, 1, 'hA,     2, 2)); // '+'
        vecs.push_back(mk(8'h39, 1,  0, 0, 0,       2, 2)); // '9'
        vecs.push_back(mk(8'h66, 1,  0, 0, 0,       2, 2)); // 'f'
        vecs.push_back(mk(8'h0A, 1,  0, 0, 0,       2, 2)); // LF
        vecs.push_back(mk(8'h2B, 1,  1, 2, 'hF9,    3, 2)); // '+'
        foreach (vecs[i]) begin
            if (vecs[i].wr) push_wr(vecs[i].addr, vecs[i].data, 1'b0);
            send(vecs[i].b, vecs[i].hold);
            chk($sformatf("vec%0d_line", i), PIXELS'(o_line), PIXELS'(vecs[i].line));
            chk($sformatf("vec%0d_err", i), PIXELS'(o_err_cnt), PIXELS'(vecs[i].err));
        end

        // Full line: 75 digits fill the word, the 76th is rejected
        send(8'h23, 1);
        for (int i = 0; i < 76; i++) send(8'h46, 1);
        chk("full_err", PIXELS'(o_err_cnt), PIXELS'(3));
        push_wr(0, all_ones, 1'b0);
        send(8'h2B, 1);
        chk("full_line", PIXELS'(o_line), PIXELS'(1));

        // Whole frame of empty lines; the last commit wraps and flags frame done
        send(8'h23, 1);
        fd_cnt = 0;
        for (int i = 0; i < LINES; i++) begin
            push_wr(ADDR_W'(i), '0, (i == LINES - 1));
            send(8'h2B, 1);
        end
        chk("frame_line_wrap", PIXELS'(o_line), '0);
        chk("frame_done_count", PIXELS'(fd_cnt), PIXELS'(1));
        chk("frame_queue_drained", PIXELS'(q.size()), '0);

        // Commit latency and pulse width while READY stays high
        push_wr(0, '0, 1'b0);
        @(negedge clk);
        i_ready = 1'b1;
        i_data  = 8'h2B;
        @(negedge clk);
        chk("wr_latency", PIXELS'(o_wr_en), PIXELS'(1));
        @(negedge clk);
        chk("wr_pulse_end", PIXELS'(o_wr_en), '0);
        repeat (3) @(negedge clk);
        chk("wr_single_pulse_line", PIXELS'(o_line), PIXELS'(1));
        i_ready = 1'b0;
        @(negedge clk);

        // Rejected-byte counter saturates at 255
        for (int i = 0; i < 260; i++) send(8'h21, 1);
        chk("err_saturate", PIXELS'(o_err_cnt), PIXELS'(255));
        send(8'h23, 1);
        chk("err_kept_by_hash", PIXELS'(o_err_cnt), PIXELS'(255));

        // Async reset mid-line after a non-zero write
        push_wr(0, 'h7, 1'b0);
        send(8'h37, 1);
        send(8'h2B, 1);
        send(8'h35, 1);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_wr_en", PIXELS'(o_wr_en), '0);
        chk("arst_wr_addr", PIXELS'(o_wr_addr), '0);
        chk("arst_wr_data", o_wr_data, '0);
        chk("arst_line", PIXELS'(o_line), '0);
        chk("arst_frame_done", PIXELS'(o_frame_done), '0);
        chk("arst_err_cnt", PIXELS'(o_err_cnt), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_wr(0, '0, 1'b0);
        send(8'h2B, 1);
        chk("post_rst_line", PIXELS'(o_line), PIXELS'(1));

        repeat (3) @(negedge clk);
        chk("final_queue_drained", PIXELS'(q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
